// File: rtl/mem_req_responder.sv
// Word-addressed backing store answering single-word host reads/writes
// after a programmable latency, with a one-entry pending slot.
module mem_req_responder #(
  parameter int unsigned ADDR_WID = 14,
  parameter int unsigned RD_LAT   = 4,
  parameter int unsigned WR_LAT   = 2,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [63:0]         read_base,
  input  logic [63:0]         write_base,
  input  logic                read_enable,
  input  logic [63:0]         read_addr,
  input  logic                write_enable,
  input  logic [63:0]         write_addr,
  input  logic [31:0]         write_data,
  input  logic                load_en,
  input  logic [ADDR_WID-1:0] load_addr,
  input  logic [31:0]         load_data,
  output logic [63:0]         read_ready,
  output logic [31:0]         read_data,
  output logic [63:0]         write_ready,
  output logic                busy,
  output logic                overflow,
  output logic                range_err,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count
);

  typedef enum logic [1:0] {
    IDLE, RD_WAIT, WR_WAIT, RESP
  } state_t;

  typedef struct packed {
    logic                wr;
    logic                oor;
    logic [ADDR_WID-1:0] idx;
    logic [31:0]         data;
  } req_t;

  localparam logic [7:0] RD_CNT0 = 8'(RD_LAT - 1);
  localparam logic [7:0] WR_CNT0 = 8'(WR_LAT - 1);

  logic [31:0] mem [0:(2**ADDR_WID)-1];

  state_t      state_q;
  logic [7:0]  cnt_q;
  req_t        cur_q;
  req_t        pend_q;
  logic        pend_v_q;
  logic        rd_rdy_q;
  logic        wr_rdy_q;
  logic [31:0] rdata_q;
  logic        ovf_q;
  logic        rerr_q;
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  logic [63:0] rd_diff;
  logic [63:0] wr_diff;
  req_t        rd_r;
  req_t        wr_r;
  req_t        new_r;
  logic        any_req;
  logic        waiting;
  logic        fire;
  logic        commit;
  logic        launch_pend;
  logic        launch_new;

  assign rd_diff = read_addr - read_base;
  assign wr_diff = write_addr - write_base;

  // Out of range: below base, misaligned, or past the store.
  always_comb begin
    rd_r      = '0;
    rd_r.wr   = 1'b0;
    rd_r.oor  = (read_addr < read_base)
              | (|read_addr[1:0])
              | (|rd_diff[1:0])
              | (|rd_diff[63:ADDR_WID+2]);
    rd_r.idx  = rd_diff[ADDR_WID+1:2];
    wr_r      = '0;
    wr_r.wr   = 1'b1;
    wr_r.oor  = (write_addr < write_base)
              | (|write_addr[1:0])
              | (|wr_diff[1:0])
              | (|wr_diff[63:ADDR_WID+2]);
    wr_r.idx  = wr_diff[ADDR_WID+1:2];
    wr_r.data = write_data;
  end

  assign new_r   = write_enable ? wr_r : rd_r;
  assign any_req = read_enable | write_enable;
  assign waiting = (state_q == RD_WAIT)
                 | (state_q == WR_WAIT);
  assign fire    = waiting & (cnt_q == 8'd0);
  assign commit  = fire & cur_q.wr & ~cur_q.oor;

  assign launch_pend = (state_q == RESP) & pend_v_q;
  assign launch_new  = any_req
                     & ((state_q == IDLE)
                     | ((state_q == RESP) & ~pend_v_q));

  function automatic logic [7:0] lat0(input logic wr);
    return wr ? WR_CNT0 : RD_CNT0;
  endfunction

  function automatic state_t wait_st(input logic wr);
    return wr ? WR_WAIT : RD_WAIT;
  endfunction

  // Preload is written last so it wins over a same-index commit.
  always_ff @(posedge clk) begin
    if (commit)
      mem[cur_q.idx] <= cur_q.data;
    if (load_en)
      mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cur_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      rd_rdy_q <= 1'b0;
      wr_rdy_q <= 1'b0;
      rdata_q  <= '0;
      ovf_q    <= 1'b0;
      rerr_q   <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_rdy_q <= 1'b0;
      wr_rdy_q <= 1'b0;
      if ((read_enable & rd_r.oor)
          | (write_enable & wr_r.oor))
        rerr_q <= 1'b1;

      if (fire) begin
        state_q <= RESP;
        if (cur_q.wr) begin
          wr_rdy_q <= 1'b1;
          wr_cnt_q <= wr_cnt_q + 32'd1;
        end else begin
          rd_rdy_q <= 1'b1;
          rdata_q  <= cur_q.oor ? ERR_WORD
                                : mem[cur_q.idx];
          rd_cnt_q <= rd_cnt_q + 32'd1;
        end
      end else if (waiting) begin
        cnt_q <= cnt_q - 8'd1;
      end

      if (launch_pend) begin
        cur_q    <= pend_q;
        pend_v_q <= 1'b0;
        cnt_q    <= lat0(pend_q.wr);
        state_q  <= wait_st(pend_q.wr);
      end else if (launch_new) begin
        cur_q   <= new_r;
        cnt_q   <= lat0(new_r.wr);
        state_q <= wait_st(new_r.wr);
        // Write goes first; the read waits for coherence.
        if (read_enable & write_enable) begin
          pend_q   <= rd_r;
          pend_v_q <= 1'b1;
        end
      end else if (state_q == RESP) begin
        state_q <= IDLE;
      end

      if (any_req & ~launch_new) begin
        if (!pend_v_q) begin
          pend_q   <= new_r;
          pend_v_q <= 1'b1;
          if (read_enable & write_enable)
            ovf_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign read_ready  = {63'd0, rd_rdy_q};
  assign write_ready = {63'd0, wr_rdy_q};
  assign read_data   = rdata_q;
  assign busy        = (state_q != IDLE) | pend_v_q;
  assign overflow    = ovf_q;
  assign range_err   = rerr_q;
  assign rd_count    = rd_cnt_q;
  assign wr_count    = wr_cnt_q;

endmodule

// File: tb/tb_mem_req_responder.sv
// Scoreboard bench for mem_req_responder: stimulus pushes expected
// responses, a negedge monitor pops and checks data and timing.
module tb_mem_req_responder;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   read_base, write_base;
  logic          read_enable, write_enable;
  logic [63:0]   read_addr, write_addr;
  logic [31:0]   write_data;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic [63:0]   read_ready, write_ready;
  logic [31:0]   read_data;
  logic          busy, overflow, range_err;
  logic [31:0]   rd_count, wr_count;

  mem_req_responder #(
    .ADDR_WID(AW), .RD_LAT(4), .WR_LAT(2),
    .ERR_WORD(32'hDEADBEEF)
  ) dut (
    .clk(clk), .reset(reset),
    .read_base(read_base), .write_base(write_base),
    .read_enable(read_enable), .read_addr(read_addr),
    .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data),
    .read_ready(read_ready), .read_data(read_data),
    .write_ready(write_ready), .busy(busy),
    .overflow(overflow), .range_err(range_err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 &&
        (read_ready != 0 || write_ready != 0)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready rd=%h wr=%h cyc=%0d",
                 read_ready, write_ready, cyc);
      end else begin
        e = sb.pop_front();
        chk("resp_cycle", 64'(cyc), 64'(e.due));
        if (e.wr) begin
          chk("write_ready", write_ready, 64'd1);
          chk("rd_ready_quiet", read_ready, 64'd0);
        end else begin
          chk("read_ready", read_ready, 64'd1);
          chk("wr_ready_quiet", write_ready, 64'd0);
          chk("read_data", 64'(read_data), 64'(e.data));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input bit wr,
                            input logic [31:0] d,
                            input int due);
    exp_t e;
    e.wr = wr;
    e.data = d;
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic preload(input logic [AW-1:0] a,
                         input logic [31:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic drain(input string nm);
    int i;
    i = 0;
    while ((sb.size() != 0 || busy) && i < 200) begin
      step();
      i++;
    end
    chk(nm, 64'(sb.size() != 0 || busy), 64'd0);
  endtask

  task automatic rd(input logic [63:0] a,
                    input logic [31:0] d);
    read_enable = 1'b1;
    read_addr = a;
    step();
    read_enable = 1'b0;
    expect_rsp(1'b0, d, cyc + 4);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rready"}, read_ready, 64'd0);
    chk({nm, "_wready"}, write_ready, 64'd0);
    chk({nm, "_rdata"}, 64'(read_data), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_ovf"}, 64'(overflow), 64'd0);
    chk({nm, "_rerr"}, 64'(range_err), 64'd0);
    chk({nm, "_rdcnt"}, 64'(rd_count), 64'd0);
    chk({nm, "_wrcnt"}, 64'(wr_count), 64'd0);
  endtask

  initial begin
    int s;
    reset = 1'b0;
    read_base = 64'h1000;
    write_base = 64'h1000;
    read_enable = 1'b0;
    write_enable = 1'b0;
    read_addr = '0;
    write_addr = '0;
    write_data = '0;
    load_en = 1'b0;
    load_addr = '0;
    load_data = '0;
    repeat (3) step();
    chk_zero("reset");
    reset = 1'b1;
    step();

    // basic read of preloaded word
    preload(14'd5, 32'h12345678);
    rd(64'h1014, 32'h12345678);
    drain("drain_rd1");
    chk("rd_count_1", 64'(rd_count), 64'd1);

    // write then read back
    write_enable = 1'b1;
    write_addr = 64'h1020;
    write_data = 32'hCAFEF00D;
    step();
    write_enable = 1'b0;
    expect_rsp(1'b1, 32'h0, cyc + 2);
    drain("drain_wr1");
    rd(64'h1020, 32'hCAFEF00D);
    drain("drain_rd2");
    chk("wr_count_1", 64'(wr_count), 64'd1);

    // simultaneous write and read, same address
    write_enable = 1'b1;
    read_enable = 1'b1;
    write_addr = 64'h1040;
    read_addr = 64'h1040;
    write_data = 32'h000000A5;
    step();
    write_enable = 1'b0;
    read_enable = 1'b0;
    expect_rsp(1'b1, 32'h0, cyc + 2);
    expect_rsp(1'b0, 32'h000000A5, cyc + 7);
    drain("drain_rw");
    chk("rd_count_3", 64'(rd_count), 64'd3);
    chk("wr_count_2", 64'(wr_count), 64'd2);
    chk("ovf_clear", 64'(overflow), 64'd0);

    // three back-to-back reads: third dropped
    preload(14'd20, 32'h00000111);
    preload(14'd21, 32'h00000222);
    read_enable = 1'b1;
    read_addr = 64'h1050;
    step();
    s = cyc;
    read_addr = 64'h1054;
    step();
    read_addr = 64'h1058;
    step();
    read_enable = 1'b0;
    expect_rsp(1'b0, 32'h00000111, s + 4);
    expect_rsp(1'b0, 32'h00000222, s + 9);
    chk("overflow_set", 64'(overflow), 64'd1);
    drain("drain_b2b");
    chk("rd_count_5", 64'(rd_count), 64'd5);

    // out-of-range reads
    chk("rerr_clear", 64'(range_err), 64'd0);
    rd(64'h1003, 32'hDEADBEEF);
    drain("drain_oor1");
    chk("rerr_set", 64'(range_err), 64'd1);
    rd(64'h1000 + 64'h10000, 32'hDEADBEEF);
    drain("drain_oor2");
    rd(64'h0FFC, 32'hDEADBEEF);
    drain("drain_oor3");
    chk("rd_count_8", 64'(rd_count), 64'd8);

    // reset during RD_WAIT
    read_enable = 1'b1;
    read_addr = 64'h1014;
    step();
    read_enable = 1'b0;
    step();
    step();
    chk("busy_mid", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk_zero("midrst");
    step();
    reset = 1'b1;
    repeat (8) step();
    chk("no_stray_busy", 64'(busy), 64'd0);
    rd(64'h1014, 32'h12345678);
    drain("drain_post_rst");
    chk("rd_count_post", 64'(rd_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
